// File: rtl/par_to_serial_tx.sv
// par_to_serial_tx: byte-to-serial transmitter. Sends a run of N_SYNC
// IDLE_SYM symbols after reset, then forwards valid bytes MSB first,
// filling with IDLE_SYM whenever no byte is offered at a symbol boundary.
module par_to_serial_tx #(
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
    parameter int unsigned     N_SYNC   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             Valid,
    output logic             DATA_OUT,
    output logic             SYM_START,
    output logic             LOAD,
    output logic             ACTIVE
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned SW = 4;

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SW-1:0]    sync_cnt_r;
    logic [SW-1:0]    sync_cnt_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shreg_r;
    logic             boundary_s;
    logic [WIDTH-1:0] sym_s;
    logic             load_nxt_s;
    logic             active_nxt_s;
    logic             data_out_r;
    logic             sym_start_r;
    logic             load_r;
    logic             active_r;

    assign boundary_s = (cnt_r == CW'(0));

    // State and sync-run counter; both move only at symbol boundaries.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_SYNC;
            sync_cnt_r <= SW'(0);
        end else begin
            state_r    <= state_nxt_s;
            sync_cnt_r <= sync_cnt_nxt_s;
        end
    end

    // Next-state decision and symbol selection for the upcoming boundary.
    always_comb begin
        state_nxt_s    = state_r;
        sync_cnt_nxt_s = sync_cnt_r;
        sym_s          = IDLE_SYM;
        load_nxt_s     = 1'b0;
        active_nxt_s   = active_r;
        case (state_r)
            ST_SYNC: begin
                if (boundary_s) begin
                    if (sync_cnt_r == SW'(N_SYNC - 1)) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        sync_cnt_nxt_s = sync_cnt_r + SW'(1);
                    end
                end else begin
                    sync_cnt_nxt_s = sync_cnt_r;
                end
            end
            ST_ACTIVE: begin
                if (boundary_s) begin
                    active_nxt_s = 1'b1;
                    if (Valid) begin
                        sym_s      = DATA_IN;
                        load_nxt_s = 1'b1;
                    end else begin
                        sym_s      = IDLE_SYM;
                        load_nxt_s = 1'b0;
                    end
                end else begin
                    active_nxt_s = active_r;
                end
            end
            default: begin
                state_nxt_s = ST_SYNC;
            end
        endcase
    end

    // Serializer datapath: load a new symbol at the boundary, else shift out.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r       <= CW'(0);
            shreg_r     <= {WIDTH{1'b0}};
            data_out_r  <= 1'b0;
            sym_start_r <= 1'b0;
            load_r      <= 1'b0;
            active_r    <= 1'b0;
        end else if (boundary_s) begin
            cnt_r       <= CW'(1);
            shreg_r     <= {sym_s[WIDTH-2:0], 1'b0};
            data_out_r  <= sym_s[WIDTH-1];
            sym_start_r <= 1'b1;
            load_r      <= load_nxt_s;
            active_r    <= active_nxt_s;
        end else begin
            cnt_r       <= (cnt_r == CW'(WIDTH - 1)) ? CW'(0) : cnt_r + CW'(1);
            shreg_r     <= {shreg_r[WIDTH-2:0], 1'b0};
            data_out_r  <= shreg_r[WIDTH-1];
            sym_start_r <= 1'b0;
            load_r      <= 1'b0;
            active_r    <= active_r;
        end
    end

    assign DATA_OUT  = data_out_r;
    assign SYM_START = sym_start_r;
    assign LOAD      = load_r;
    assign ACTIVE    = active_r;

endmodule

// File: tb/tb_par_to_serial_tx.sv
// Bench for par_to_serial_tx: directed symbol table, reset corner cases and
// a long random run, all checked every cycle against a symbol-level model.
module tb_par_to_serial_tx;

    localparam int N_SYNC = 4;
    localparam logic [7:0] IDLE = 8'hBC;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] DATA_IN = 8'h00;
    logic       Valid = 1'b0;
    logic       DATA_OUT, SYM_START, LOAD, ACTIVE;

    int checks = 0;
    int errors = 0;

    // Reference model state: position within the symbol, symbols since reset.
    int         m_pos  = 0;
    int         m_nsym = 0;
    logic [7:0] m_cur  = 8'h00;
    logic       m_out, m_ss, m_load, m_act;
    logic [7:0] got_sym = 8'h00;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] exp_sym;
        logic       exp_load;
    } vec_t;

    vec_t vecs[8];

    par_to_serial_tx dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .Valid(Valid),
        .DATA_OUT(DATA_OUT), .SYM_START(SYM_START), .LOAD(LOAD), .ACTIVE(ACTIVE)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic rst, input logic v, input logic [7:0] d);
        logic [7:0] s;
        RESET = rst; Valid = v; DATA_IN = d;
        @(posedge CLK);
        if (rst) begin
            m_pos = 0; m_nsym = 0; m_cur = 8'h00;
            m_out = 1'b0; m_ss = 1'b0; m_load = 1'b0; m_act = 1'b0;
        end else begin
            if (m_pos == 0) begin
                if (m_nsym < N_SYNC) begin
                    s = IDLE; m_load = 1'b0; m_act = 1'b0;
                end else begin
                    s = v ? d : IDLE; m_load = v; m_act = 1'b1;
                end
                m_cur = s;
                m_ss  = 1'b1;
                if (m_nsym < 100) m_nsym++;
            end else begin
                m_ss = 1'b0; m_load = 1'b0;
            end
            m_out = m_cur[7 - m_pos];
            m_pos = (m_pos + 1) % 8;
        end
        #1;
        chk("data_out",  {7'd0, DATA_OUT},  {7'd0, m_out});
        chk("sym_start", {7'd0, SYM_START}, {7'd0, m_ss});
        chk("load",      {7'd0, LOAD},      {7'd0, m_load});
        chk("active",    {7'd0, ACTIVE},    {7'd0, m_act});
        got_sym = {got_sym[6:0], DATA_OUT};
    endtask

    // One whole symbol with inputs held; reports flags seen on its first bit.
    task automatic send_sym(input logic v, input logic [7:0] d, output logic [7:0] sym,
                            output logic ss0, output logic ld0, output logic act0);
        ss0 = 1'b0; ld0 = 1'b0; act0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, v, d);
            if (i == 0) begin
                ss0 = SYM_START; ld0 = LOAD; act0 = ACTIVE;
            end
        end
        sym = got_sym;
    endtask

    initial begin
        logic [7:0] sym;
        logic ss0, ld0, act0;
        logic rv;
        logic [7:0] rd;

        vecs[0] = '{1'b1, 8'h25, 8'h25, 1'b1};
        vecs[1] = '{1'b1, 8'h28, 8'h28, 1'b1};
        vecs[2] = '{1'b1, 8'hF9, 8'hF9, 1'b1};
        vecs[3] = '{1'b1, 8'h4F, 8'h4F, 1'b1};
        vecs[4] = '{1'b1, 8'hA6, 8'hA6, 1'b1};
        vecs[5] = '{1'b0, 8'h77, 8'hBC, 1'b0};
        vecs[6] = '{1'b1, 8'h39, 8'h39, 1'b1};
        vecs[7] = '{1'b1, 8'hBC, 8'hBC, 1'b1};

        // Reset held for several cycles with inputs wiggling.
        for (int i = 0; i < 6; i++) step(1'b1, i[0], 8'(i * 37));
        chk("reset_data_out", {7'd0, DATA_OUT}, 8'h00);
        chk("reset_active",   {7'd0, ACTIVE},   8'h00);

        // Sync run ignores Valid and DATA_IN.
        for (int i = 0; i < N_SYNC; i++) begin
            send_sym(1'b1, 8'hF9, sym, ss0, ld0, act0);
            chk("sync_sym", sym, 8'hBC);
            chk("sync_sym_start", {7'd0, ss0}, 8'h01);
            chk("sync_load", {7'd0, ld0}, 8'h00);
            chk("sync_active", {7'd0, act0}, 8'h00);
        end
        send_sym(1'b1, 8'hF9, sym, ss0, ld0, act0);
        chk("first_active_sym", sym, 8'hF9);
        chk("first_active_load", {7'd0, ld0}, 8'h01);
        chk("first_active_active", {7'd0, act0}, 8'h01);

        // Back-to-back table of active symbols, including an idle gap.
        for (int i = 0; i < 8; i++) begin
            send_sym(vecs[i].v, vecs[i].d, sym, ss0, ld0, act0);
            chk($sformatf("vec%0d_sym", i), sym, vecs[i].exp_sym);
            chk($sformatf("vec%0d_load", i), {7'd0, ld0}, {7'd0, vecs[i].exp_load});
            chk($sformatf("vec%0d_sym_start", i), {7'd0, ss0}, 8'h01);
            chk($sformatf("vec%0d_active", i), {7'd0, act0}, 8'h01);
        end

        // Reset in the middle of a symbol, at the edge where cnt is 3.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h4F);
        step(1'b1, 1'b1, 8'h4F);
        chk("midrst_data_out", {7'd0, DATA_OUT}, 8'h00);
        chk("midrst_active", {7'd0, ACTIVE}, 8'h00);
        chk("midrst_sym_start", {7'd0, SYM_START}, 8'h00);
        for (int i = 0; i < N_SYNC; i++) begin
            send_sym(1'b1, 8'h4F, sym, ss0, ld0, act0);
            chk("resync_sym", sym, 8'hBC);
            chk("resync_sym_start", {7'd0, ss0}, 8'h01);
            chk("resync_active", {7'd0, act0}, 8'h00);
        end
        send_sym(1'b1, 8'h4F, sym, ss0, ld0, act0);
        chk("after_resync_sym", sym, 8'h4F);

        // Random traffic with short-held bytes and occasional resets.
        rv = 1'b0; rd = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                rv = 1'($urandom_range(0, 1));
                rd = 8'($urandom_range(0, 255));
            end
            step(($urandom_range(0, 299) == 0), rv, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
